// File: rtl/kdtree_pkg.sv
// Shared sizes, patch type and load-sequencer state encoding for the kd-tree loader.
package kdtree_pkg;

    localparam int DATA_WIDTH  = 11;
    localparam int PATCH_SIZE  = 5;
    localparam int LEAF_SIZE   = 8;
    localparam int NUM_LEAVES  = 64;
    localparam int NUM_NODES   = NUM_LEAVES - 1;
    localparam int NUM_QUERYS  = 494;
    localparam int ADDR_WIDTH  = $clog2(NUM_LEAVES);
    localparam int QADDR_WIDTH = $clog2(NUM_QUERYS);
    localparam int SLOT_WIDTH  = $clog2(LEAF_SIZE);
    localparam int WC_WIDTH    = $clog2(PATCH_SIZE + 1);
    localparam int PATCH_W     = PATCH_SIZE * DATA_WIDTH;

    typedef logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] patch_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_NODES,
        LOAD_LEAVES,
        LOAD_QUERIES,
        DONE
    } load_state_t;

endpackage

// File: rtl/kdtree_load_ctrl_patch_assembler.sv
// Collects one FIFO word per component into a patch; patch_nxt already includes the word being loaded.
module patch_assembler
    import kdtree_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WC_WIDTH-1:0]   wc,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [PATCH_W-1:0]    patch_nxt,
    output logic                  last
);

    patch_t patch_q;
    patch_t patch_d;

    always_comb begin
        patch_d = patch_q;
        for (int i = 0; i < PATCH_SIZE; i++) begin
            if (load && (wc == WC_WIDTH'(i))) begin
                patch_d[i] = data;
            end
        end
    end

    assign patch_nxt = patch_d;
    assign last      = load && (wc == WC_WIDTH'(PATCH_SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            patch_q <= '0;
        end else if (clr) begin
            patch_q <= '0;
        end else if (load) begin
            patch_q <= patch_d;
        end
    end

endmodule

// File: rtl/kdtree_load_ctrl.sv
// Splits the shared input FIFO stream into node, leaf and query write transactions after load_kdtree.
module kdtree_load_ctrl
    import kdtree_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_kdtree,
    input  logic [DATA_WIDTH-1:0]  in_fifo_rdata,
    input  logic                   in_fifo_rempty_n,
    output logic                   in_fifo_rdeq,
    output logic                   node_wen,
    output logic [ADDR_WIDTH-1:0]  node_waddr,
    output logic [2:0]             node_windex,
    output logic [DATA_WIDTH-1:0]  node_wmedian,
    output logic                   leaf_wen,
    output logic [ADDR_WIDTH-1:0]  leaf_waddr,
    output logic [SLOT_WIDTH-1:0]  leaf_wslot,
    output logic [PATCH_W-1:0]     leaf_wdata,
    output logic [DATA_WIDTH-1:0]  leaf_widx,
    output logic                   query_wen,
    output logic [QADDR_WIDTH-1:0] query_waddr,
    output logic [PATCH_W-1:0]     query_wdata,
    output logic                   busy,
    output logic                   load_done
);

    localparam logic [WC_WIDTH-1:0] WC_MEDIAN   = WC_WIDTH'(1);
    localparam logic [WC_WIDTH-1:0] WC_LEAF_IDX = WC_WIDTH'(PATCH_SIZE);

    load_state_t state, state_nxt;

    logic [WC_WIDTH-1:0]    wc;
    logic [ADDR_WIDTH-1:0]  node_cnt;
    logic [ADDR_WIDTH-1:0]  leaf_cnt;
    logic [SLOT_WIDTH-1:0]  slot;
    logic [QADDR_WIDTH-1:0] query_cnt;
    logic [2:0]             idx_q;

    logic start, node_end, leaf_end, query_end;
    logic node_last, slot_last, leaf_last, query_last;
    logic asm_load, asm_last;
    logic [PATCH_W-1:0] patch_nxt;

    assign start      = load_kdtree & ~busy;
    assign node_end   = in_fifo_rdeq & (state == LOAD_NODES) & (wc == WC_MEDIAN);
    assign leaf_end   = in_fifo_rdeq & (state == LOAD_LEAVES) & (wc == WC_LEAF_IDX);
    assign asm_load   = in_fifo_rdeq & ((state == LOAD_LEAVES) | (state == LOAD_QUERIES))
                        & (wc < WC_LEAF_IDX);
    assign query_end  = asm_last & (state == LOAD_QUERIES);
    assign node_last  = (node_cnt == ADDR_WIDTH'(NUM_NODES - 1));
    assign slot_last  = (slot == SLOT_WIDTH'(LEAF_SIZE - 1));
    assign leaf_last  = (leaf_cnt == ADDR_WIDTH'(NUM_LEAVES - 1)) & slot_last;
    assign query_last = (query_cnt == QADDR_WIDTH'(NUM_QUERYS - 1));

    patch_assembler u_patch_assembler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start),
        .load      (asm_load),
        .wc        (wc),
        .data      (in_fifo_rdata),
        .patch_nxt (patch_nxt),
        .last      (asm_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE:   if (start) state_nxt = LOAD_NODES;
            LOAD_NODES:   if (node_end && node_last) state_nxt = LOAD_LEAVES;
            LOAD_LEAVES:  if (leaf_end && leaf_last) state_nxt = LOAD_QUERIES;
            LOAD_QUERIES: if (query_end && query_last) state_nxt = DONE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        load_done = 1'b0;
        case (state)
            LOAD_NODES, LOAD_LEAVES, LOAD_QUERIES: busy = 1'b1;
            DONE:                                  load_done = 1'b1;
            default:                               ;
        endcase
        in_fifo_rdeq = busy & in_fifo_rempty_n;
    end

    // Item counters: wc restarts at every item boundary, everything holds while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc        <= '0;
            node_cnt  <= '0;
            leaf_cnt  <= '0;
            slot      <= '0;
            query_cnt <= '0;
            idx_q     <= '0;
        end else if (start) begin
            wc        <= '0;
            node_cnt  <= '0;
            leaf_cnt  <= '0;
            slot      <= '0;
            query_cnt <= '0;
            idx_q     <= '0;
        end else if (node_end) begin
            wc       <= '0;
            node_cnt <= node_cnt + 1'b1;
        end else if (leaf_end) begin
            wc <= '0;
            if (slot_last) begin
                slot     <= '0;
                leaf_cnt <= leaf_cnt + 1'b1;
            end else begin
                slot <= slot + 1'b1;
            end
        end else if (query_end) begin
            wc        <= '0;
            query_cnt <= query_cnt + 1'b1;
        end else if (in_fifo_rdeq) begin
            if (state == LOAD_NODES) begin
                idx_q <= in_fifo_rdata[2:0];
            end
            wc <= wc + 1'b1;
        end
    end

    // Write ports: strobes pulse for one cycle, address/data hold until the next write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_wen     <= 1'b0;
            node_waddr   <= '0;
            node_windex  <= '0;
            node_wmedian <= '0;
            leaf_wen     <= 1'b0;
            leaf_waddr   <= '0;
            leaf_wslot   <= '0;
            leaf_wdata   <= '0;
            leaf_widx    <= '0;
            query_wen    <= 1'b0;
            query_waddr  <= '0;
            query_wdata  <= '0;
        end else begin
            node_wen  <= node_end;
            leaf_wen  <= leaf_end;
            query_wen <= query_end;
            if (node_end) begin
                node_waddr   <= node_cnt;
                node_windex  <= idx_q;
                node_wmedian <= in_fifo_rdata;
            end
            if (leaf_end) begin
                leaf_waddr <= leaf_cnt;
                leaf_wslot <= slot;
                leaf_wdata <= patch_nxt;
                leaf_widx  <= in_fifo_rdata;
            end
            if (query_end) begin
                query_waddr <= query_cnt;
                query_wdata <= patch_nxt;
            end
        end
    end

endmodule

// File: tb/tb_kdtree_load_ctrl.sv
// Randomized frame streaming against a word-index reference model of the kd-tree loader.
module tb_kdtree_load_ctrl;

    localparam int LEAF_BASE  = 126;
    localparam int QUERY_BASE = 126 + 3072;
    localparam int N_TOTAL    = QUERY_BASE + 2470;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_kdtree;
    logic [10:0] in_fifo_rdata;
    logic        in_fifo_rempty_n;
    logic        in_fifo_rdeq;
    logic        node_wen;
    logic [5:0]  node_waddr;
    logic [2:0]  node_windex;
    logic [10:0] node_wmedian;
    logic        leaf_wen;
    logic [5:0]  leaf_waddr;
    logic [2:0]  leaf_wslot;
    logic [54:0] leaf_wdata;
    logic [10:0] leaf_widx;
    logic        query_wen;
    logic [8:0]  query_waddr;
    logic [54:0] query_wdata;
    logic        busy;
    logic        load_done;

    kdtree_load_ctrl dut (
        .clk(clk), .rst_n(rst_n), .load_kdtree(load_kdtree),
        .in_fifo_rdata(in_fifo_rdata), .in_fifo_rempty_n(in_fifo_rempty_n),
        .in_fifo_rdeq(in_fifo_rdeq),
        .node_wen(node_wen), .node_waddr(node_waddr), .node_windex(node_windex),
        .node_wmedian(node_wmedian),
        .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_wslot(leaf_wslot),
        .leaf_wdata(leaf_wdata), .leaf_widx(leaf_widx),
        .query_wen(query_wen), .query_waddr(query_waddr), .query_wdata(query_wdata),
        .busy(busy), .load_done(load_done)
    );

    always #5 clk = ~clk;

    logic [10:0] frame [N_TOTAL];
    logic [10:0] q [$];
    int  total = 0;
    int  bad = 0;
    int  p = 0;
    bit  active = 0;
    bit  done_flag = 0;
    int  pend_kind = 0;
    int  pend_item = 0;
    int  frame_id = 0;
    bit  toggle = 0;
    int  n_node, n_leaf, n_query;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic build_frame(input bit directed);
        for (int i = 0; i < N_TOTAL; i++) frame[i] = 11'($urandom_range(0, 2047));
        if (directed) begin
            frame[0] = 11'd3; frame[1] = 11'd512; frame[2] = 11'd1; frame[3] = 11'd100;
            for (int c = 0; c < 5; c++) frame[LEAF_BASE + c] = 11'(c + 1);
            frame[LEAF_BASE + 5] = 11'd77;
        end
        q.delete();
        for (int i = 0; i < N_TOTAL; i++) q.push_back(frame[i]);
        for (int i = 0; i < 20; i++) q.push_back(11'($urandom_range(0, 2047)));
    endtask

    // Which write (if any) the word at stream position idx completes.
    task automatic item_kind(input int idx, output int kind, output int item);
        int r;
        kind = 0;
        item = 0;
        if (idx < LEAF_BASE) begin
            if (idx % 2 == 1) begin kind = 1; item = idx / 2; end
        end else if (idx < QUERY_BASE) begin
            r = idx - LEAF_BASE;
            if (r % 6 == 5) begin kind = 2; item = r / 6; end
        end else begin
            r = idx - QUERY_BASE;
            if (r % 5 == 4) begin kind = 3; item = r / 5; end
        end
    endtask

    task automatic check_cycle();
        logic [54:0] v;
        int base;
        if (node_wen)  n_node++;
        if (leaf_wen)  n_leaf++;
        if (query_wen) n_query++;
        check("node_wen", node_wen, pend_kind == 1);
        check("leaf_wen", leaf_wen, pend_kind == 2);
        check("query_wen", query_wen, pend_kind == 3);
        check("busy", busy, active);
        check("load_done", load_done, done_flag);
        if (pend_kind == 1) begin
            check("node_waddr", node_waddr, pend_item);
            check("node_windex", node_windex, frame[2*pend_item] & 11'd7);
            check("node_wmedian", node_wmedian, frame[2*pend_item+1]);
        end else if (pend_kind == 2) begin
            base = LEAF_BASE + 6*pend_item;
            for (int c = 0; c < 5; c++) v[c*11 +: 11] = frame[base + c];
            check("leaf_waddr", leaf_waddr, pend_item / 8);
            check("leaf_wslot", leaf_wslot, pend_item % 8);
            check("leaf_wdata", leaf_wdata, v);
            check("leaf_widx", leaf_widx, frame[base + 5]);
        end else if (pend_kind == 3) begin
            base = QUERY_BASE + 5*pend_item;
            for (int c = 0; c < 5; c++) v[c*11 +: 11] = frame[base + c];
            check("query_waddr", query_waddr, pend_item);
            check("query_wdata", query_wdata, v);
        end
        pend_kind = 0;
    endtask

    task automatic run_cycle(input bit lk);
        bit avail;
        bit popped;
        int k, it;
        @(negedge clk);
        check_cycle();
        load_kdtree = lk;
        if (frame_id == 1) begin
            if (p < LEAF_BASE) avail = ($urandom_range(0, 9) >= 3);
            else if (p < QUERY_BASE) avail = 1'b1;
            else begin toggle = ~toggle; avail = toggle; end
        end else begin
            avail = ($urandom_range(0, 3) != 0);
        end
        in_fifo_rempty_n = avail && (q.size() > 0);
        in_fifo_rdata = (q.size() > 0) ? q[0] : 11'($urandom_range(0, 2047));
        #1;
        check("rdeq", in_fifo_rdeq, active && in_fifo_rempty_n);
        popped = in_fifo_rdeq;
        @(posedge clk);
        if (popped && q.size() > 0) void'(q.pop_front());
        if (lk && !active) begin
            active = 1; done_flag = 0; p = 0;
        end else if (popped && active) begin
            item_kind(p, k, it);
            pend_kind = k;
            pend_item = it;
            if (p == N_TOTAL - 1) begin active = 0; done_flag = 1; end
            p++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rdeq"}, in_fifo_rdeq, 0);
        check({tag, "_strobes"}, {node_wen, leaf_wen, query_wen}, 0);
        check({tag, "_node"}, {node_waddr, node_windex, node_wmedian}, 0);
        check({tag, "_leaf_meta"}, {leaf_waddr, leaf_wslot, leaf_widx}, 0);
        check({tag, "_leaf_wdata"}, leaf_wdata, 0);
        check({tag, "_query"}, {query_waddr, query_wdata}, 0);
        check({tag, "_status"}, {busy, load_done}, 0);
    endtask

    task automatic run_frame(input string tag);
        int cyc = 0;
        bit lk_done = 0;
        bit lk;
        n_node = 0; n_leaf = 0; n_query = 0;
        run_cycle(1);
        while (!done_flag && cyc < 20000) begin
            lk = (frame_id == 1) && (p == LEAF_BASE + 40) && !lk_done;
            if (lk) lk_done = 1;
            run_cycle(lk);
            cyc++;
        end
        check({tag, "_finished"}, done_flag, 1);
        repeat (4) run_cycle(0);
        check({tag, "_n_node"}, n_node, 63);
        check({tag, "_n_leaf"}, n_leaf, 512);
        check({tag, "_n_query"}, n_query, 494);
        check({tag, "_words_left"}, q.size() > 0, 1);
        check({tag, "_held_addrs"}, {node_waddr, leaf_waddr, leaf_wslot, query_waddr},
              {6'd62, 6'd63, 3'd7, 9'd493});
    endtask

    initial begin
        int cyc;
        rst_n = 0;
        load_kdtree = 0;
        in_fifo_rdata = 11'h7ff;
        in_fifo_rempty_n = 1;
        repeat (2) @(negedge clk);
        check_zero("por");
        rst_n = 1;

        // Start a frame and pull reset three words into the leaf section.
        frame_id = 0;
        build_frame(0);
        run_cycle(1);
        cyc = 0;
        while (p < LEAF_BASE + 3 && cyc < 2000) begin run_cycle(0); cyc++; end
        check("abort_reached", p, LEAF_BASE + 3);
        #2;
        rst_n = 0;
        #1;
        check_zero("midrst");
        active = 0; done_flag = 0; pend_kind = 0; p = 0;
        q.delete();
        repeat (2) @(negedge clk);
        check_zero("midrst_hold");
        rst_n = 1;

        frame_id = 1;
        build_frame(1);
        run_frame("frame1");

        frame_id = 2;
        build_frame(0);
        run_frame("frame2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
